// File: rtl/bcd_counter_if.sv
// Handshake/bus bundle between a BCD counter and whatever drives/observes it.
// The master side supplies count/load controls; the slave side is the counter.
interface bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tc;
  logic                  load_err;
  logic                  wrapped;

  modport master (
    output en, up, load, load_val,
    input  bcd, tc, load_err, wrapped
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, tc, load_err, wrapped
  );
endinterface

// File: rtl/bcd_counter.sv
// N-digit BCD up/down counter with validated parallel load. Every digit is
// kept in 0..9; a load containing any A..F digit is dropped and flagged.

module bcd_digit (
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       up,
  output logic [3:0] nxt,
  output logic       co
);
  // ci is the carry (up) or borrow (down) arriving from the digit below
  always_comb begin
    nxt = d;
    co  = 1'b0;
    if (ci) begin
      if (up) begin
        co  = (d == 4'd9);
        nxt = co ? 4'd0 : d + 4'd1;
      end else begin
        co  = (d == 4'd0);
        nxt = co ? 4'd9 : d - 4'd1;
      end
    end
  end
endmodule

module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  bcd_counter_if.slave  bus
);
  logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
  logic [DIGITS-1:0][3:0] cnt_nxt;
  logic [DIGITS-1:0][3:0] ld;
  logic [DIGITS:0]        chain;
  logic                   wrapped_q, wrapped_d;
  logic                   load_err_q, load_err_d;
  logic                   load_ok, all9, all0;

  assign ld       = bus.load_val;
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d   (bcd_q[g]),
      .ci  (chain[g]),
      .up  (bus.up),
      .nxt (cnt_nxt[g]),
      .co  (chain[g+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ld[k] > 4'd9)     load_ok = 1'b0;
      if (bcd_q[k] != 4'd9) all9    = 1'b0;
      if (bcd_q[k] != 4'd0) all0    = 1'b0;
    end
  end

  // Rejected loads still consume the cycle: no count happens alongside them
  always_comb begin
    bcd_d      = bcd_q;
    wrapped_d  = wrapped_q;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        bcd_d     = ld;
        wrapped_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      bcd_d = cnt_nxt;
      if (chain[DIGITS]) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q      <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.load_err = load_err_q;
  // Gated by rst so a cascaded stage never sees a spurious enable in reset
  assign bus.tc = ~rst & bus.en & ~bus.load & (bus.up ? all9 : all0);
endmodule

// File: tb/tb_bcd_counter.sv
// Directed-vector bench for bcd_counter (DIGITS=2) with per-cycle digit legality check.
module tb_bcd_counter;
  localparam int DIGITS = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] gray_exp [10];

  bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic up, input logic load, input logic [7:0] lv);
    bus.en       = en;
    bus.up       = up;
    bus.load     = load;
    bus.load_val = lv;
  endtask

  // Nothing downstream may ever see a non-BCD digit
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DIGITS; k++) begin
        checks++;
        assert (bus.bcd[4*k +: 4] <= 4'd9) else begin
          errors++;
          $error("FAIL digit_legal observed=%0h expected<=9", bus.bcd[4*k +: 4]);
        end
      end
    end
  end

  initial begin
    gray_exp[0] = 4'b0000; gray_exp[1] = 4'b0001; gray_exp[2] = 4'b0011;
    gray_exp[3] = 4'b0010; gray_exp[4] = 4'b0110; gray_exp[5] = 4'b0111;
    gray_exp[6] = 4'b0101; gray_exp[7] = 4'b0100; gray_exp[8] = 4'b1100;
    gray_exp[9] = 4'b1101;
    checks = 0;
    errors = 0;

    // Reset state; en=1 up=0 with bcd=0 must still keep tc low
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #2;
    chk("rst_bcd", 32'(bus.bcd), 32'h00);
    chk("rst_err", 32'(bus.load_err), 32'h0);
    chk("rst_wrap", 32'(bus.wrapped), 32'h0);
    chk("rst_tc", 32'(bus.tc), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h35);
    step();
    chk("ld35", 32'(bus.bcd), 32'h35);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    step();
    chk("cnt37", 32'(bus.bcd), 32'h37);
    drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_bcd", 32'(bus.bcd), 32'h00);
    chk("async_err", 32'(bus.load_err), 32'h0);
    chk("async_wrap", 32'(bus.wrapped), 32'h0);
    #1;
    rst = 1'b0;

    // Up with carry and wrap
    drive(1'b0, 1'b1, 1'b1, 8'h97);
    step();
    chk("ld97", 32'(bus.bcd), 32'h97);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    chk("tc97", 32'(bus.tc), 32'h0);
    step();
    chk("up98", 32'(bus.bcd), 32'h98);
    chk("tc98", 32'(bus.tc), 32'h0);
    step();
    chk("up99", 32'(bus.bcd), 32'h99);
    chk("tc99", 32'(bus.tc), 32'h1);
    chk("wrap99", 32'(bus.wrapped), 32'h0);
    step();
    chk("up00", 32'(bus.bcd), 32'h00);
    chk("tc00_up", 32'(bus.tc), 32'h0);
    chk("wrap00", 32'(bus.wrapped), 32'h1);
    step();
    chk("up01", 32'(bus.bcd), 32'h01);
    chk("wrap01", 32'(bus.wrapped), 32'h1);

    // Down with borrow and wrap
    drive(1'b1, 1'b0, 1'b1, 8'h10);
    step();
    chk("ld10", 32'(bus.bcd), 32'h10);
    chk("ld10_wrap", 32'(bus.wrapped), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    chk("dn09", 32'(bus.bcd), 32'h09);
    step();
    chk("dn08", 32'(bus.bcd), 32'h08);
    step();
    chk("dn07", 32'(bus.bcd), 32'h07);
    drive(1'b1, 1'b0, 1'b1, 8'h01);
    chk("tc_ld", 32'(bus.tc), 32'h0);
    step();
    chk("ld01", 32'(bus.bcd), 32'h01);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    chk("dn00", 32'(bus.bcd), 32'h00);
    chk("tc00_dn", 32'(bus.tc), 32'h1);
    step();
    chk("dn99", 32'(bus.bcd), 32'h99);
    chk("dn99_wrap", 32'(bus.wrapped), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("tc_hold", 32'(bus.tc), 32'h0);

    // Invalid load leaves bcd and wrapped alone, pulses load_err
    drive(1'b1, 1'b1, 1'b1, 8'hF9);
    step();
    chk("badF9_bcd", 32'(bus.bcd), 32'h99);
    chk("badF9_wrap", 32'(bus.wrapped), 32'h1);
    chk("badF9_err", 32'(bus.load_err), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("hold_err", 32'(bus.load_err), 32'h0);
    chk("hold_bcd", 32'(bus.bcd), 32'h99);
    drive(1'b0, 1'b1, 1'b1, 8'h42);
    step();
    chk("ld42", 32'(bus.bcd), 32'h42);
    drive(1'b1, 1'b1, 1'b1, 8'h3A);
    step();
    chk("bad3A_bcd", 32'(bus.bcd), 32'h42);
    chk("bad3A_err", 32'(bus.load_err), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 8'h55);
    step();
    chk("ld55", 32'(bus.bcd), 32'h55);
    chk("ld55_err", 32'(bus.load_err), 32'h0);
    chk("ld55_wrap", 32'(bus.wrapped), 32'h0);

    // Load beats enable, then direction flips every cycle
    drive(1'b0, 1'b1, 1'b1, 8'h50);
    step();
    chk("ld50", 32'(bus.bcd), 32'h50);
    drive(1'b1, 1'b1, 1'b1, 8'h20);
    step();
    chk("prio20", 32'(bus.bcd), 32'h20);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    chk("flip21a", 32'(bus.bcd), 32'h21);
    bus.up = 1'b0;
    step();
    chk("flip20a", 32'(bus.bcd), 32'h20);
    bus.up = 1'b1;
    step();
    chk("flip21b", 32'(bus.bcd), 32'h21);
    bus.up = 1'b0;
    step();
    chk("flip20b", 32'(bus.bcd), 32'h20);

    // Low digit through a BCD-to-Gray conversion, 0..9
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("gray%0d", i),
          32'(bus.bcd[3:0] ^ (bus.bcd[3:0] >> 1)), 32'(gray_exp[i]));
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("after_gray", 32'(bus.bcd), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
